mem_cache: RTL and testbench
============================

# mem_cache

Direct-mapped, write-through, no-write-allocate word cache between the multicycle MIPS core and the backing `memory`. The core's `mr`/`mw` requests are served from the cache on a read hit and forwarded to `memory` otherwise. A `ready` handshake lets the core stall while the cache is busy. One word per line, byte addresses, word-aligned accesses only.

## Interface
- `LINES`, 16: number of cache lines; power of two, ≥2. `IDX = log2(LINES)`.
- `MEM_LAT`, 2: cycles `mem_mr` is held before `mem_read_data` is sampled; 1..15.
- `clk` input 1: clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `address` input 32: byte address from core; bits [1:0] ignored.
- `write_data` input 32: store data from core.
- `mr` input 1: core read request; held until `ready`.
- `mw` input 1: core write request; held until `ready`.
- `read_data` output 32: load data to core; valid only when `ready`=1 on a read.
- `ready` output 1: request complete this cycle.
- `mem_address` output 32: address to backing memory.
- `mem_write_data` output 32: store data to backing memory.
- `mem_mr` output 1: backing memory read enable.
- `mem_mw` output 1: backing memory write enable; memory writes on the rising edge.
- `mem_read_data` input 32: backing memory read data.

## Operation
- Fields: `index = address[IDX+1:2]`, `tag = address[31:IDX+2]`. Per line: valid bit, tag, 32-bit data.
- Hit: valid[index] and stored tag == tag.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE, `mw`=1: go to WRITE. `mw` takes priority over `mr` if both are asserted.
- IDLE, `mr`=1, hit: `ready`=1 combinationally and `read_data`=line data. Stay in IDLE.
- IDLE, `mr`=1, miss: latch address. Load the latency counter with MEM_LAT. Go to FILL.
- FILL: `mem_mr`=1 and `mem_address`=latched address. Counter decrements each cycle.
  - On the last FILL cycle (counter=1): capture `mem_read_data` into the line (set valid, write tag) and into a fill register. Go to DONE.
- WRITE: one cycle. `mem_mw`=1, `mem_address`=latched address, `mem_write_data`=latched data.
  - On a hit, the line data is updated on the same edge.
  - On a miss the line is unchanged (no-allocate). Go to DONE.
- DONE: one cycle, `ready`=1, return to IDLE.
  - After a read, `read_data`=fill register. After a write, `read_data`=0.
- Core protocol:
  - The core deasserts `mr`/`mw` in the cycle after `ready`.
  - A request still asserted in IDLE after DONE is serviced again. For a read this is a hit, so it is harmless. For a write it is rewritten.
- `read_data`, `mem_address`, and `mem_write_data` are 0 whenever they are not driven as above.
- Reset:
  - Clears all valid bits. FSM goes to IDLE, counter to 0, latches to 0.
  - Outputs after reset: `ready`=0, `mem_mr`=0, `mem_mw`=0, `read_data`=0, `mem_address`=0, `mem_write_data`=0.
  - Reset during FILL or WRITE aborts the access: no line update, no `ready`.
  - A WRITE cycle coincident with reset still presents `mem_mw` combinationally. The memory write on that edge is allowed.

## Timing
- Read hit: 0-cycle latency. `ready` and data appear in the same cycle `mr` is seen in IDLE.
- Read miss: request seen at cycle 0; `mem_mr` high cycles 1..MEM_LAT; `ready` at cycle MEM_LAT+1.
- Write (hit or miss): `mem_mw` high at cycle 1; `ready` at cycle 2.
- Requests arriving outside IDLE are ignored until the FSM returns to IDLE.
- `mem_mr` and `mem_mw` are never both 1 in the same cycle.

## Configuration
- `CACHE_STATS_EN` defined:
  - Adds 32-bit output ports `hit_count` and `miss_count`, both reset to 0.
  - `hit_count` increments once per read hit in IDLE. `miss_count` increments once per IDLE→FILL transition.
  - Writes are not counted. Counters wrap at 2^32.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then `mr` at 0x00000040: miss. `mem_mr` high for 2 cycles with `mem_address`=0x40. Memory returns 0xDEADBEEF; `ready` at cycle 3 with `read_data`=0xDEADBEEF.
- Re-read 0x40 after `ready` drops: `ready`=1 in the same cycle, `read_data`=0xDEADBEEF, `mem_mr` stays 0.
- Conflict: read 0x80 (LINES=16, same index as 0x40) → miss and refill. Then read 0x40 → miss again.
- Write 0x12345678 to cached 0x40: `mem_mw`=1 at cycle 1, `ready` at cycle 2. Next read of 0x40 hits with 0x12345678.
- Write to uncached 0xC4: memory updated, no allocation. Following read of 0xC4 misses.
- Assert `rst` during the second FILL cycle: no `ready`, line not valid. A later read of the same address misses. With `CACHE_STATS_EN`, both counters are 0 after reset.

Source files
------------

// File: rtl/mem_cache.sv
// Direct-mapped, write-through, no-write-allocate one-word-per-line cache for the multicycle MIPS core.
// Define CACHE_STATS_EN to add the hit_count / miss_count statistics ports.
module mem_cache #(
    parameter int LINES   = 16,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mr,
    input  logic        mw,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_mr,
    output logic        mem_mw,
    input  logic [31:0] mem_read_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX = $clog2(LINES);
    localparam int TAG_W = 30 - IDX;
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t state, state_next;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags  [LINES];
    logic [31:0]      lines [LINES];

    logic [3:0]  lat_cnt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] fill_q;
    logic        was_write;

    logic [IDX-1:0]   idx_in, idx_q;
    logic [TAG_W-1:0] tag_in, tag_q;
    logic             hit_in, hit_q;
    logic             unused_addr_bits;

    // Byte offset is ignored: accesses are always word aligned.
    assign unused_addr_bits = ^address[1:0];

    assign idx_in = address[IDX+1:2];
    assign tag_in = address[31:IDX+2];
    assign idx_q  = addr_q[IDX+1:2];
    assign tag_q  = addr_q[31:IDX+2];
    assign hit_in = valid[idx_in] && (tags[idx_in] == tag_in);
    assign hit_q  = valid[idx_q] && (tags[idx_q] == tag_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= 4'd0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            fill_q    <= 32'd0;
            was_write <= 1'b0;
            valid     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (mw) begin
                        addr_q    <= address;
                        data_q    <= write_data;
                        was_write <= 1'b1;
                    end else if (mr && !hit_in) begin
                        addr_q    <= address;
                        lat_cnt   <= LAT_INIT;
                        was_write <= 1'b0;
                    end
                end
                FILL: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        valid[idx_q] <= 1'b1;
                        tags[idx_q]  <= tag_q;
                        lines[idx_q] <= mem_read_data;
                        fill_q       <= mem_read_data;
                    end
                end
                // No-write-allocate: only a line already holding this address is refreshed.
                WRITE: begin
                    if (hit_q) lines[idx_q] <= data_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next     = state;
        ready          = 1'b0;
        read_data      = 32'd0;
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        mem_mr         = 1'b0;
        mem_mw         = 1'b0;
        case (state)
            IDLE: begin
                if (mw) begin
                    state_next = WRITE;
                end else if (mr) begin
                    if (hit_in) begin
                        ready     = 1'b1;
                        read_data = lines[idx_in];
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                mem_mr      = 1'b1;
                mem_address = addr_q;
                if (lat_cnt == 4'd1) state_next = DONE;
            end
            WRITE: begin
                mem_mw         = 1'b1;
                mem_address    = addr_q;
                mem_write_data = data_q;
                state_next     = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                read_data  = was_write ? 32'd0 : fill_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if (state == IDLE && mr && !mw) begin
            if (hit_in) hit_count <= hit_count + 32'd1;
            else        miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_cache.sv
// Directed scoreboard bench for mem_cache with a behavioural backing memory.
// Also checks the statistics counters when CACHE_STATS_EN is defined.
module tb_mem_cache;

    localparam int LINES   = 16;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, write_data;
    logic        mr, mw;
    logic [31:0] read_data;
    logic        ready;
    logic [31:0] mem_address, mem_write_data;
    logic        mem_mr, mem_mw;
    logic [31:0] mem_read_data;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] sb[$];
    logic [31:0] written [logic [31:0]];

    mem_cache #(.LINES(LINES), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .address(address),
        .write_data(write_data),
        .mr(mr),
        .mw(mw),
        .read_data(read_data),
        .ready(ready),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_mr(mem_mr),
        .mem_mw(mem_mw),
        .mem_read_data(mem_read_data)
`ifdef CACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] backing_init(input logic [31:0] a);
        case (a)
            32'h40:  return 32'hDEADBEEF;
            32'h80:  return 32'hCAFEF00D;
            default: return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        if (written.exists(a)) return written[a];
        return backing_init(a);
    endfunction

    // Backing memory: writes on the rising edge, combinational read while mem_mr is high.
    always @(posedge clk) begin
        if (mem_mw) written[mem_address] = mem_write_data;
    end

    always_comb begin
        mem_read_data = 32'h0;
        if (mem_mr) mem_read_data = mem_peek(mem_address);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
        check({tag, "_hits"}, hit_count, 32'(exp_hits));
        check({tag, "_misses"}, miss_count, 32'(exp_misses));
`else
        $display("[TB] %s: statistics counters not built", tag);
`endif
    endtask

    task automatic read_req(input string tag, input logic [31:0] a, input logic [31:0] exp_data,
                            input bit exp_hit);
        int  mr_cycles = 0;
        int  lat = -1;
        bit  done = 0;
        int  exp_lat = exp_hit ? 0 : MEM_LAT + 1;
        sb.push_back(exp_data);
        if (exp_hit) exp_hits++;
        else         exp_misses++;
        @(posedge clk); #1;
        address = a;
        mr = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            check({tag, "_excl"}, 32'(mem_mr & mem_mw), 32'd0);
            if (mem_mr) begin
                mr_cycles++;
                check({tag, "_mem_addr"}, mem_address, a);
            end
            if (ready) begin
                done = 1;
                lat = c;
                check({tag, "_data"}, read_data, sb.pop_front());
            end
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("[TB] FAIL %s_timeout: observed no ready expected ready", tag);
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_mem_mr_cycles"}, 32'(mr_cycles), exp_hit ? 32'd0 : 32'(MEM_LAT));
        @(posedge clk); #1;
        mr = 1'b0;
        address = 32'h0;
    endtask

    task automatic write_req(input string tag, input logic [31:0] a, input logic [31:0] d);
        int mw_cycles = 0;
        int mw_at = -1;
        int lat = -1;
        bit done = 0;
        sb.push_back(32'h0);
        @(posedge clk); #1;
        address = a;
        write_data = d;
        mw = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            check({tag, "_excl"}, 32'(mem_mr & mem_mw), 32'd0);
            if (mem_mw) begin
                mw_cycles++;
                mw_at = c;
                check({tag, "_mem_addr"}, mem_address, a);
                check({tag, "_mem_wdata"}, mem_write_data, d);
            end
            if (ready) begin
                done = 1;
                lat = c;
                check({tag, "_rdata_zero"}, read_data, sb.pop_front());
            end
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("[TB] FAIL %s_timeout: observed no ready expected ready", tag);
        end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_mw_cycles"}, 32'(mw_cycles), 32'd1);
        check({tag, "_mw_at"}, 32'(mw_at), 32'd1);
        @(posedge clk); #1;
        mw = 1'b0;
        address = 32'h0;
        write_data = 32'h0;
        check({tag, "_memory"}, mem_peek(a), d);
    endtask

    initial begin
        rst = 1'b1;
        mr = 1'b0;
        mw = 1'b0;
        address = 32'h0;
        write_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_mem_mr", 32'(mem_mr), 32'd0);
        check("rst_mem_mw", 32'(mem_mw), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check_stats("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] read miss / hit / conflict");
        read_req("miss_40", 32'h40, 32'hDEADBEEF, 1'b0);
        read_req("hit_40", 32'h40, 32'hDEADBEEF, 1'b1);
        read_req("miss_80", 32'h80, 32'hCAFEF00D, 1'b0);
        read_req("conflict_40", 32'h40, 32'hDEADBEEF, 1'b0);

        $display("[TB] write hit and write miss");
        write_req("wr_hit_40", 32'h40, 32'h12345678);
        read_req("hit_after_wr", 32'h40, 32'h12345678, 1'b1);
        write_req("wr_miss_c4", 32'hC4, 32'h0BADCAFE);
        read_req("miss_c4", 32'hC4, 32'h0BADCAFE, 1'b0);
        check_stats("mid");

        $display("[TB] reset during fill");
        @(posedge clk); #1;
        address = 32'h208;
        mr = 1'b1;
        @(negedge clk);
        check("abort_c0_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_c1_mem_mr", 32'(mem_mr), 32'd1);
        check("abort_c1_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_c2_mem_mr", 32'(mem_mr), 32'd1);
        check("abort_c2_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mr = 1'b0;
        address = 32'h0;
        exp_hits = 0;
        exp_misses = 0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_mem_mr", 32'(mem_mr), 32'd0);
        check("abort_read_data", read_data, 32'd0);
        check_stats("abort");

        read_req("miss_208", 32'h208, backing_init(32'h208), 1'b0);
        read_req("miss_40_after_rst", 32'h40, 32'h12345678, 1'b0);
        read_req("hit_208", 32'h208, backing_init(32'h208), 1'b1);
        check_stats("final");
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
